ah_demux_pkt: RTL and testbench
===============================

# ah_demux_pkt

Packet-aware, registered 1-to-N valid/ready demultiplexer, parametrised in data width and egress count. It is the successor to the combinational AH demux. It latches the egress select on the first beat of each packet and holds it until the last beat is accepted. It registers the datapath through a two-entry skid stage, so the ingress sees full throughput with no combinational ready path. It discards and counts packets whose select is out of range. It sits between an ingress stream source and N downstream consumers in the AH stream fabric.

## Interface
Parameters:
- DATA_W, default 8: payload width per beat.
- NUM_EGR, default 34: number of egress ports, from 2 to 256.
- SEL_W, default $clog2(NUM_EGR): select width.
- CNT_W, default 16: drop-counter width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- select  in  SEL_W  egress index; sampled only on the first beat of a packet.
- ing_data  in  DATA_W  ingress payload.
- ing_last  in  1  marks the final beat of a packet.
- ing_valid  in  1  ingress beat valid.
- ing_ready  out  1  ingress may transfer.
- egr_data  out  NUM_EGR*DATA_W  flattened egress payloads; slice i belongs to port i.
- egr_last  out  NUM_EGR  per-port last flag.
- egr_valid  out  NUM_EGR  per-port valid; at most one bit is set in any cycle.
- egr_ready  in  NUM_EGR  per-port ready.
- drop_cnt  out  CNT_W  saturating count of discarded packets.

## Operation
- Ingress transfer: ing_valid & ing_ready. Egress transfer on port i: egr_valid[i] & egr_ready[i].
- Packet FSM, advanced only on ingress transfers:
  - IDLE: the next ingress transfer is a first beat.
    - If select < NUM_EGR, latch it into dest. Go to PKT, or stay in IDLE if ing_last is set.
    - If select >= NUM_EGR, go to DROP, or stay in IDLE if ing_last is set; increment drop_cnt.
  - PKT: beats are tagged with dest. Return to IDLE on a transfer with ing_last set.
  - DROP: beats are accepted and discarded. Return to IDLE on a transfer with ing_last set.
- Within a packet, select changes are ignored. A single-beat packet (ing_last on the first beat) is legal and leaves the FSM in IDLE.
- Skid stage: an output register (out_v, out_dest, out_data, out_last) backed by a skid register of the same fields. Beats leave strictly in ingress order.
  - An accepted non-dropped beat loads the output register if it is empty or draining this cycle; otherwise it loads the skid register.
  - When the output register drains and the skid register is full, the skid contents move to the output register.
- egr_valid[i] = out_v & (out_dest == i).
- egr_data slice i and egr_last[i] carry out_data/out_last when out_dest == i; otherwise they are zero.
- ing_ready = !skid_v & !rst. It is registered-only and has no combinational path from egr_ready.
- Dropped beats are always accepted while ing_ready is high. They never occupy storage.
- drop_cnt saturates at 2^CNT_W-1 and never wraps.
- Head-of-line: a stalled egress port blocks subsequent packets to any port. This is intended.

## Timing
- Reset values: ing_ready 0 while rst is high and 1 in the first cycle after reset; egr_valid all 0; egr_data and egr_last all 0; drop_cnt 0; FSM IDLE; both storage entries empty.
- Latency: a beat accepted at edge k is presented on its egress from cycle k+1.
- Throughput: one beat per cycle sustained while the destination port holds egr_ready high.
- Stall: if the destination port deasserts egr_ready, the skid register fills on the next accept, and ing_ready drops one cycle later. At most 2 beats are buffered.
- Simultaneous drain and accept with the skid register empty: the new beat goes straight to the output register and ing_ready stays 1.
- Once asserted, egr_valid holds with stable data/last until the transfer completes.
- Reset mid-packet: the FSM returns to IDLE and buffered beats are discarded without being presented. The next ingress beat is treated as a first beat.

## Structure
- The shared package ah_stream_pkg holds:
  - the FSM state enum (ST_IDLE, ST_PKT, ST_DROP);
  - the beat struct {dest, data, last}.
- One sub-module, ah_skid_buf: a generic two-entry valid/ready skid buffer over the beat struct.
- The top level holds the FSM, the select range check, egress fan-out decode and drop_cnt.

## Test plan
- NUM_EGR=34, DATA_W=8. Packet of 3 beats (0x11, 0x22, 0x33 with last) with select=5, and select changed to 9 on beats 2–3 -> all 3 beats appear on port 5 only, at cycles k+1..k+3; egr_last[5] is set on 0x33.
- Back-to-back single-beat packets to ports 0, 33, 0, with all ready -> one beat per cycle; ing_ready is never deasserted.
- Port 7 holds egr_ready=0 for 4 cycles during a 6-beat packet -> 2 beats are buffered; ing_ready is 0 from the cycle after the skid fills; no beat is lost or reordered once ready returns.
- select=40 for a 4-beat packet -> all beats are accepted, no egr_valid is set, drop_cnt goes 0->1; a following packet with select=2 is delivered normally.
- CNT_W=2 with 5 out-of-range packets -> drop_cnt reads 3 and holds.
- rst asserted while 2 beats of a packet to port 12 are buffered -> next cycle: egr_valid is 0 and ing_ready is 0; after release, a packet with select=3 goes to port 3.

Source files
------------

// File: rtl/ah_stream_pkg.sv
// ---------------------------------------------------------------------------
// ah_stream_pkg
// Shared declarations for the AH stream fabric blocks.
//   pkt_state_e : packet tracking state of a packet-aware stream block
//   ah_beat_t   : reference beat layout {dest, data, last}. Blocks whose
//                 dest/data widths are parameterised declare a beat struct
//                 with the same field names and order at their own widths.
// ---------------------------------------------------------------------------
package ah_stream_pkg;

    // Packet tracking state: waiting for a first beat, forwarding a packet,
    // or discarding a packet whose select was out of range.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } pkt_state_e;

    localparam int unsigned BEAT_DEST_W = 8;
    localparam int unsigned BEAT_DATA_W = 8;

    // One stream beat tagged with its egress destination.
    typedef struct packed {
        logic [BEAT_DEST_W-1:0] dest;
        logic [BEAT_DATA_W-1:0] data;
        logic                   last;
    } ah_beat_t;

endpackage

// File: rtl/ah_demux_pkt_if.sv
// ---------------------------------------------------------------------------
// ah_demux_pkt_if
// Signal bundle of the packet-aware 1-to-N demultiplexer.
//   select     : egress index, sampled on the first beat of a packet
//   ing_data   : ingress payload          ing_last  : final beat of packet
//   ing_valid  : ingress beat valid       ing_ready : ingress may transfer
//   egr_data   : flattened egress payloads, slice i belongs to port i
//   egr_last   : per-port last flag       egr_valid : per-port valid
//   egr_ready  : per-port ready           drop_cnt  : discarded packet count
// Modports: master = stream source / consumers side, slave = demux side.
// ---------------------------------------------------------------------------
interface ah_demux_pkt_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_EGR = 34,
    parameter int unsigned SEL_W   = $clog2(NUM_EGR),
    parameter int unsigned CNT_W   = 16
);
    logic [SEL_W-1:0]          select;
    logic [DATA_W-1:0]         ing_data;
    logic                      ing_last;
    logic                      ing_valid;
    logic                      ing_ready;
    logic [NUM_EGR*DATA_W-1:0] egr_data;
    logic [NUM_EGR-1:0]        egr_last;
    logic [NUM_EGR-1:0]        egr_valid;
    logic [NUM_EGR-1:0]        egr_ready;
    logic [CNT_W-1:0]          drop_cnt;

    modport master (
        output select, ing_data, ing_last, ing_valid, egr_ready,
        input  ing_ready, egr_data, egr_last, egr_valid, drop_cnt
    );

    modport slave (
        input  select, ing_data, ing_last, ing_valid, egr_ready,
        output ing_ready, egr_data, egr_last, egr_valid, drop_cnt
    );
endinterface

// File: rtl/ah_skid_buf.sv
// ---------------------------------------------------------------------------
// ah_skid_buf
// Generic two-entry valid/ready skid buffer. The output register presents
// the oldest beat; the skid register catches one beat that arrives while
// the output is stalled. i_ready never reaches o_ready combinationally.
//   clk, rst : clock, synchronous active-high reset
//   i_data, i_valid, o_ready : upstream side
//   o_data, o_valid, i_ready : downstream side
// ---------------------------------------------------------------------------
module ah_skid_buf
    import ah_stream_pkg::*;
#(
    parameter type T = ah_beat_t
) (
    input  logic clk,
    input  logic rst,
    input  T     i_data,
    input  logic i_valid,
    output logic o_ready,
    output T     o_data,
    output logic o_valid,
    input  logic i_ready
);

    logic r_out_v;
    logic r_skid_v;
    T     r_out_d;
    T     r_skid_d;
    logic w_push;
    logic w_out_free;

    // Reset is folded in so no beat is accepted while reset is held.
    assign o_ready    = !r_skid_v & !rst;
    assign w_push     = i_valid & o_ready;
    assign w_out_free = !r_out_v | i_ready;
    assign o_data     = r_out_d;
    assign o_valid    = r_out_v;

    // Storage update: skid contents have priority for the output register
    // so beats leave in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out_d  <= '0;
            r_skid_d <= '0;
        end else if (w_out_free) begin
            if (r_skid_v) begin
                r_out_v  <= 1'b1;
                r_out_d  <= r_skid_d;
                r_skid_v <= 1'b0;
            end else if (w_push) begin
                r_out_v  <= 1'b1;
                r_out_d  <= i_data;
            end else begin
                r_out_v  <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_v <= 1'b1;
            r_skid_d <= i_data;
        end else begin
            r_skid_v <= r_skid_v;
        end
    end

endmodule

// File: rtl/ah_demux_pkt.sv
// ---------------------------------------------------------------------------
// ah_demux_pkt
// Packet-aware registered 1-to-N valid/ready demultiplexer. The egress
// select is latched on the first beat of a packet and held until its last
// beat; packets with an out-of-range select are accepted, discarded and
// counted. Beats are registered through a two-entry skid buffer.
//   clk : clock            rst : synchronous active-high reset
//   bus : ah_demux_pkt_if.slave (ingress stream, egress fan-out, drop_cnt)
// ---------------------------------------------------------------------------
module ah_demux_pkt
    import ah_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_EGR = 34,
    parameter int unsigned SEL_W   = $clog2(NUM_EGR),
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    ah_demux_pkt_if.slave bus
);

    typedef struct packed {
        logic [SEL_W-1:0]  dest;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    pkt_state_e                r_state;
    pkt_state_e                w_state_nxt;
    logic [SEL_W-1:0]          r_dest;
    logic [SEL_W-1:0]          w_dest_nxt;
    logic [SEL_W-1:0]          w_beat_dest;
    logic [CNT_W-1:0]          r_drop_cnt;
    logic                      w_ing_ready;
    logic                      w_xfer;
    logic                      w_sel_ok;
    logic                      w_drop_beat;
    logic                      w_cnt_inc;
    logic                      w_drain_rdy;
    beat_t                     w_in_beat;
    beat_t                     w_out_beat;
    logic                      w_out_v;
    logic [NUM_EGR-1:0]        w_egr_valid;
    logic [NUM_EGR-1:0]        w_egr_last;
    logic [NUM_EGR*DATA_W-1:0] w_egr_data;

    assign w_xfer    = bus.ing_valid & w_ing_ready;
    assign w_sel_ok  = ({{(32-SEL_W){1'b0}}, bus.select} < NUM_EGR);
    assign w_in_beat = {w_beat_dest, bus.ing_data, bus.ing_last};

    // Packet state register; only ingress transfers move it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dest  <= {SEL_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_dest  <= w_dest_nxt;
        end
    end

    // Next packet state, beat destination and drop decision.
    always_comb begin
        w_state_nxt = r_state;
        w_dest_nxt  = r_dest;
        w_beat_dest = r_dest;
        w_drop_beat = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // First beat: route on the live select, not the latched one.
                w_beat_dest = bus.select;
                if (w_sel_ok) begin
                    w_dest_nxt  = w_xfer ? bus.select : r_dest;
                    w_state_nxt = (w_xfer && !bus.ing_last) ? ST_PKT : ST_IDLE;
                end else begin
                    w_drop_beat = 1'b1;
                    w_cnt_inc   = w_xfer;
                    w_state_nxt = (w_xfer && !bus.ing_last) ? ST_DROP : ST_IDLE;
                end
            end
            ST_PKT: begin
                w_state_nxt = (w_xfer && bus.ing_last) ? ST_IDLE : ST_PKT;
            end
            ST_DROP: begin
                w_drop_beat = 1'b1;
                w_state_nxt = (w_xfer && bus.ing_last) ? ST_IDLE : ST_DROP;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Saturating drop counter, stepped on the first beat of a dropped packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_inc && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    // Dropped beats never enter storage, but ing_ready still governs them.
    ah_skid_buf #(
        .T (beat_t)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_in_beat),
        .i_valid (bus.ing_valid & !w_drop_beat),
        .o_ready (w_ing_ready),
        .o_data  (w_out_beat),
        .o_valid (w_out_v),
        .i_ready (w_drain_rdy)
    );

    // Egress fan-out: only the slice addressed by the output register is live.
    always_comb begin
        w_egr_valid = {NUM_EGR{1'b0}};
        w_egr_last  = {NUM_EGR{1'b0}};
        w_egr_data  = {(NUM_EGR*DATA_W){1'b0}};
        for (int i = 0; i < NUM_EGR; i++) begin
            if (w_out_beat.dest == SEL_W'(i)) begin
                w_egr_valid[i]                = w_out_v;
                w_egr_last[i]                 = w_out_beat.last;
                w_egr_data[i*DATA_W +: DATA_W] = w_out_beat.data;
            end else begin
                w_egr_valid[i] = 1'b0;
            end
        end
    end

    assign w_drain_rdy   = |(w_egr_valid & bus.egr_ready);
    assign bus.ing_ready = w_ing_ready;
    assign bus.egr_valid = w_egr_valid;
    assign bus.egr_last  = w_egr_last;
    assign bus.egr_data  = w_egr_data;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_ah_demux_pkt.sv
// ---------------------------------------------------------------------------
// tb_ah_demux_pkt
// Self-checking bench for ah_demux_pkt. A second instance with a 2-bit drop
// counter shares the same stimulus to exercise saturation. The reference
// model keeps the beats awaiting delivery as a queue in acceptance order.
// ---------------------------------------------------------------------------
module tb_ah_demux_pkt;

    localparam int DW = 8;
    localparam int NE = 34;
    localparam int SW = $clog2(NE);
    localparam int VW = NE * DW;

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] data;
        logic          last;
    } tx_beat_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          last;
    } exp_beat_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ah_demux_pkt_if #(.DATA_W(DW), .NUM_EGR(NE), .SEL_W(SW), .CNT_W(16)) bus ();
    ah_demux_pkt_if #(.DATA_W(DW), .NUM_EGR(NE), .SEL_W(SW), .CNT_W(2))  bus2 ();

    assign bus2.select    = bus.select;
    assign bus2.ing_data  = bus.ing_data;
    assign bus2.ing_last  = bus.ing_last;
    assign bus2.ing_valid = bus.ing_valid;
    assign bus2.egr_ready = bus.egr_ready;

    ah_demux_pkt #(.DATA_W(DW), .NUM_EGR(NE), .SEL_W(SW), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ah_demux_pkt #(.DATA_W(DW), .NUM_EGR(NE), .SEL_W(SW), .CNT_W(2)) u_dut_c2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int        n_total = 0;
    int        n_bad   = 0;
    tx_beat_t  tx_q[$];
    exp_beat_t exp_q[$];
    bit        m_in_pkt = 1'b0;
    bit        m_drop   = 1'b0;
    int        m_dest   = 0;
    int        m_drops  = 0;
    bit        m_clean  = 1'b1;

    localparam logic [NE-1:0] ALL_RDY = {NE{1'b1}};

    task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int sel, input int data, input bit last);
        tx_beat_t b;
        b.sel  = SW'(sel);
        b.data = DW'(data);
        b.last = last;
        tx_q.push_back(b);
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // then advance the model across the coming rising edge.
    task automatic step(input logic [NE-1:0] rdy, input logic rst_v, input bit rnd_valid);
        logic          vld;
        logic          exp_rdy;
        logic [VW-1:0] exp_v;
        logic [VW-1:0] exp_l;
        logic [VW-1:0] exp_d;
        exp_beat_t     e;
        int            p;
        rst           = rst_v;
        bus.egr_ready = rdy;
        vld = (tx_q.size() > 0) && (!rnd_valid || ($urandom_range(3, 0) != 0));
        bus.ing_valid = vld;
        if (tx_q.size() > 0) begin
            bus.select   = tx_q[0].sel;
            bus.ing_data = tx_q[0].data;
            bus.ing_last = tx_q[0].last;
        end else begin
            bus.select   = SW'($urandom_range(63, 0));
            bus.ing_data = DW'($urandom_range(255, 0));
            bus.ing_last = 1'b0;
        end
        #1;
        exp_rdy = !rst_v && (exp_q.size() < 2);
        exp_v = '0;
        exp_l = '0;
        exp_d = '0;
        if (exp_q.size() > 0) begin
            p = exp_q[0].port;
            exp_v[p]          = 1'b1;
            exp_l[p]          = exp_q[0].last;
            exp_d[p*DW +: DW] = exp_q[0].data;
        end
        check_eq("ing_ready", bus.ing_ready, exp_rdy);
        check_eq("egr_valid", bus.egr_valid, exp_v);
        if (exp_q.size() > 0 || m_clean) begin
            check_eq("egr_data", bus.egr_data, exp_d);
            check_eq("egr_last", bus.egr_last, exp_l);
        end
        check_eq("drop_cnt", bus.drop_cnt, m_drops);
        check_eq("drop_cnt_w2", bus2.drop_cnt, (m_drops > 3) ? 3 : m_drops);
        // Model update for the coming edge.
        if (exp_q.size() > 0 && rdy[exp_q[0].port]) begin
            exp_q.pop_front();
        end
        if (vld && exp_rdy) begin
            if (!m_in_pkt) begin
                if (int'(tx_q[0].sel) < NE) begin
                    m_dest = int'(tx_q[0].sel);
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                    m_drops++;
                end
            end
            if (!m_drop) begin
                e.port = m_dest;
                e.data = tx_q[0].data;
                e.last = tx_q[0].last;
                exp_q.push_back(e);
                m_clean = 1'b0;
            end
            m_in_pkt = !tx_q[0].last;
            tx_q.pop_front();
        end
        if (rst_v) begin
            exp_q.delete();
            m_in_pkt = 1'b0;
            m_drop   = 1'b0;
            m_drops  = 0;
            m_clean  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run with all ports ready until everything is sent and delivered.
    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && (tx_q.size() > 0 || exp_q.size() > 0); k++) begin
            step(ALL_RDY, 1'b0, 1'b0);
        end
        check_eq(tag, tx_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        logic [NE-1:0] r;
        int            len;
        int            sel;
        rst           = 1'b1;
        bus.select    = '0;
        bus.ing_data  = '0;
        bus.ing_last  = 1'b0;
        bus.ing_valid = 1'b0;
        bus.egr_ready = ALL_RDY;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then release.
        step(ALL_RDY, 1'b1, 1'b0);
        step(ALL_RDY, 1'b0, 1'b0);

        // Three-beat packet to port 5; select changes mid-packet are ignored.
        push_beat(5, 8'h11, 1'b0);
        push_beat(9, 8'h22, 1'b0);
        push_beat(9, 8'h33, 1'b1);
        drain("pkt3_drain", 10);

        // Back-to-back single-beat packets.
        push_beat(0, 8'h40, 1'b1);
        push_beat(33, 8'h41, 1'b1);
        push_beat(0, 8'h42, 1'b1);
        drain("b2b_drain", 10);

        // Port 7 stalls for 4 cycles during a 6-beat packet.
        for (int j = 0; j < 6; j++) push_beat(7, 8'hA0 + j, j == 5);
        step(ALL_RDY, 1'b0, 1'b0);
        r = ALL_RDY;
        r[7] = 1'b0;
        repeat (4) step(r, 1'b0, 1'b0);
        check_eq("stall_buffered", exp_q.size(), 2);
        drain("stall_drain", 20);

        // Out-of-range select, then a normal packet to port 2.
        for (int j = 0; j < 4; j++) push_beat(40, 8'hC0 + j, j == 3);
        push_beat(2, 8'hD0, 1'b0);
        push_beat(2, 8'hD1, 1'b1);
        drain("drop40_drain", 20);
        check_eq("drop40_cnt", bus.drop_cnt, 1);

        // Five more dropped packets saturate the 2-bit counter.
        for (int n = 0; n < 5; n++) begin
            len = $urandom_range(3, 1);
            sel = $urandom_range(63, NE);
            for (int j = 0; j < len; j++) push_beat(sel, $urandom_range(255, 0), j == len - 1);
        end
        drain("drops_drain", 40);
        check_eq("drop_sat_w2", bus2.drop_cnt, 3);
        check_eq("drop_cnt_6", bus.drop_cnt, 6);

        // Reset while two beats to port 12 are buffered.
        for (int j = 0; j < 5; j++) push_beat(12, 8'h60 + j, j == 4);
        r = ALL_RDY;
        r[12] = 1'b0;
        repeat (3) step(r, 1'b0, 1'b0);
        check_eq("rst_buffered", exp_q.size(), 2);
        step(r, 1'b1, 1'b0);
        step(r, 1'b1, 1'b0);
        tx_q.delete();
        step(ALL_RDY, 1'b0, 1'b0);
        push_beat(3, 8'h77, 1'b0);
        push_beat(3, 8'h78, 1'b1);
        drain("post_rst_drain", 10);

        // Randomised traffic with random gaps and back-pressure.
        for (int c = 0; c < 400; c++) begin
            if (tx_q.size() == 0) begin
                len = $urandom_range(4, 1);
                sel = ($urandom_range(3, 0) == 0) ? $urandom_range(63, NE) : $urandom_range(NE - 1, 0);
                for (int j = 0; j < len; j++) push_beat(sel, $urandom_range(255, 0), j == len - 1);
            end
            for (int b = 0; b < NE; b++) r[b] = ($urandom_range(3, 0) != 0);
            step(r, 1'b0, 1'b1);
        end
        drain("rand_drain", 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
